// File: rtl/difftest_axis_packer_if.sv
// Handshake bundle between the difftest producer, the packer and the XDMA stream sink.
// The slave modport is the packer's view; master is the surrounding producer/sink view.
interface difftest_axis_packer_if;
   logic         in_valid;
   logic         in_ready;
   logic [511:0] in_data;
   logic         flush;
   logic         axi_tvalid;
   logic         axi_tready;
   logic [511:0] axi_tdata;
   logic         axi_tlast;
   logic         busy;
   logic [31:0]  frame_cnt;

   modport slave (
      input  in_valid,
      input  in_data,
      input  flush,
      input  axi_tready,
      output in_ready,
      output axi_tvalid,
      output axi_tdata,
      output axi_tlast,
      output busy,
      output frame_cnt
   );

   modport master (
      output in_valid,
      output in_data,
      output flush,
      output axi_tready,
      input  in_ready,
      input  axi_tvalid,
      input  axi_tdata,
      input  axi_tlast,
      input  busy,
      input  frame_cnt
   );
endinterface

// File: rtl/difftest_axis_packer.sv
// Buffers 512-bit difftest beats and emits them as fixed-length AXI-stream frames,
// zero-padding a partial frame when a flush is requested.
module difftest_axis_packer #(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned FRAME_BEATS = 8
) (
   input logic                   clock,
   input logic                   reset,
   difftest_axis_packer_if.slave bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned BW = $clog2(FRAME_BEATS);
   localparam logic [BW-1:0] LastBeat = BW'(FRAME_BEATS - 1);

   typedef enum logic [0:0] {StStream, StPad} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
   logic            flush_pending_q, flush_pending_d;
   logic [31:0]     frame_cnt_q, frame_cnt_d;
   logic [511:0]    mem_q [DEPTH];

   logic            full, empty;
   logic            in_ready, push, pop;
   logic            tvalid, tlast, out_hs;
   logic [511:0]    tdata;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   // Reset gates in_ready combinationally so nothing is accepted while reset is held.
   assign in_ready = !reset && !full && !flush_pending_q;
   assign push     = bus.in_valid && in_ready;
   assign out_hs   = tvalid && bus.axi_tready;
   assign pop      = (state_q == StStream) && out_hs;

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StStream;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StStream: begin
            if (flush_pending_q && empty && (beat_cnt_q != '0)) begin
               state_d = StPad;
            end
         end
         StPad: begin
            if (out_hs && tlast) begin
               state_d = StStream;
            end
         end
         default: state_d = StStream;
      endcase
   end

   // Output logic; head data is held because pops only happen on a handshake
   always_comb begin
      tvalid = 1'b0;
      tdata  = '0;
      unique case (state_q)
         StStream: begin
            tvalid = !empty;
            tdata  = empty ? '0 : mem_q[rd_ptr_q];
         end
         StPad: begin
            tvalid = 1'b1;
            tdata  = '0;
         end
         default: begin
            tvalid = 1'b0;
            tdata  = '0;
         end
      endcase
      tlast = tvalid && (beat_cnt_q == LastBeat);
   end

   always_comb begin
      wr_ptr_d        = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d        = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d         = count_q + CW'(push) - CW'(pop);
      beat_cnt_d      = beat_cnt_q;
      frame_cnt_d     = frame_cnt_q;
      flush_pending_d = flush_pending_q;

      if (out_hs) begin
         beat_cnt_d = tlast ? '0 : beat_cnt_q + BW'(1);
         if (tlast) begin
            frame_cnt_d = frame_cnt_q + 32'd1;
         end
      end

      if (!flush_pending_q && bus.flush) begin
         flush_pending_d = 1'b1;
      end
      // Flush landed exactly on a frame boundary: nothing to pad.
      if ((state_q == StStream) && flush_pending_q && empty && (beat_cnt_q == '0)) begin
         flush_pending_d = 1'b0;
      end
      if ((state_q == StPad) && out_hs && tlast) begin
         flush_pending_d = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         beat_cnt_q      <= '0;
         flush_pending_q <= 1'b0;
         frame_cnt_q     <= '0;
      end else begin
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
         beat_cnt_q      <= beat_cnt_d;
         flush_pending_q <= flush_pending_d;
         frame_cnt_q     <= frame_cnt_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.in_data;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.axi_tvalid = tvalid;
   assign bus.axi_tdata  = tdata;
   assign bus.axi_tlast  = tlast;
   assign bus.busy       = flush_pending_q || (state_q == StPad);
   assign bus.frame_cnt  = frame_cnt_q;

endmodule
